// File: rtl/histo_readout.sv
// Histogram readout: sweeps every bin of the histogram memory after an image completes
// and streams a framed word sequence (header, bin counts, sum trailer) over valid/ready.
module histo_readout #(
  parameter int         NUM_BINS   = 1024,
  parameter int         RD_LATENCY = 2,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        histo_done,
  output logic        hist_rw,
  output logic [9:0]  hist_bin,
  input  logic [23:0] hist_data,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        busy,
  output logic [7:0]  frame_id,
  output logic        overrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 2;
  // Stage 0 marks an address presented on hist_bin; the top stage marks hist_data valid.
  localparam int PW = RD_LATENCY + 1;
  localparam logic [9:0] LAST_BIN = 10'(NUM_BINS - 1);

  typedef enum logic [2:0] {IDLE, HEADER, SWEEP, DRAIN, TRAILER} state_t;

  state_t          state_reg, state_next;
  logic [9:0]      hist_bin_reg, next_bin_reg;
  logic [PW-1:0]   rd_pipe_reg;
  logic [31:0]     sum_reg;
  logic [7:0]      frame_id_reg;
  logic            overrun_reg;
  logic            trailer_pushed_reg;

  logic [32:0]     fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg;

  logic            issue, fsm_push, push, pop, trailer_done, credit_ok;
  logic [32:0]     fsm_word, push_word;
  logic [CW-1:0]   inflight;

  assign m_valid      = (count_reg != '0);
  assign m_data       = m_valid ? fifo_mem[rd_ptr_reg][31:0] : 32'd0;
  assign m_last       = m_valid & fifo_mem[rd_ptr_reg][32];
  assign pop          = m_valid & m_ready;
  assign trailer_done = pop & m_last;

  assign hist_rw  = (state_reg == IDLE);
  assign busy     = (state_reg != IDLE);
  assign hist_bin = hist_bin_reg;
  assign frame_id = frame_id_reg;
  assign overrun  = overrun_reg;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < PW; i++) inflight = inflight + CW'(rd_pipe_reg[i]);
  end

  // Every outstanding read owns a FIFO slot; a slot freed by this cycle's pop counts too.
  assign credit_ok = (count_reg + inflight) < (CW'(FIFO_DEPTH) + CW'(pop));

  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    fsm_push   = 1'b0;
    fsm_word   = '0;
    case (state_reg)
      IDLE: begin
        if (histo_done) state_next = HEADER;
      end
      HEADER: begin
        fsm_push   = 1'b1;
        fsm_word   = {1'b0, SYNC_BYTE, frame_id_reg, 16'(NUM_BINS)};
        state_next = SWEEP;
      end
      SWEEP: begin
        issue = credit_ok;
        if (credit_ok && next_bin_reg == LAST_BIN) state_next = DRAIN;
      end
      DRAIN: begin
        if (rd_pipe_reg == '0) state_next = TRAILER;
      end
      TRAILER: begin
        if (!trailer_pushed_reg && count_reg < CW'(FIFO_DEPTH)) begin
          fsm_push = 1'b1;
          fsm_word = {1'b1, sum_reg};
        end
        if (trailer_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Header and trailer are only pushed while no reads are in flight, so they never collide.
  assign push      = fsm_push | rd_pipe_reg[PW-1];
  assign push_word = rd_pipe_reg[PW-1] ? {9'd0, hist_data} : fsm_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg          <= IDLE;
      hist_bin_reg       <= '0;
      next_bin_reg       <= '0;
      rd_pipe_reg        <= '0;
      sum_reg            <= '0;
      frame_id_reg       <= '0;
      overrun_reg        <= 1'b0;
      trailer_pushed_reg <= 1'b0;
      wr_ptr_reg         <= '0;
      rd_ptr_reg         <= '0;
      count_reg          <= '0;
    end else begin
      state_reg   <= state_next;
      rd_pipe_reg <= {rd_pipe_reg[PW-2:0], issue};
      if (issue) begin
        hist_bin_reg <= next_bin_reg;
        next_bin_reg <= next_bin_reg + 10'd1;
      end
      if (state_reg == IDLE && histo_done) begin
        sum_reg            <= '0;
        next_bin_reg       <= '0;
        trailer_pushed_reg <= 1'b0;
      end else if (rd_pipe_reg[PW-1]) begin
        sum_reg <= sum_reg + 32'(hist_data);
      end
      if (state_reg == TRAILER && fsm_push) trailer_pushed_reg <= 1'b1;
      if (trailer_done) frame_id_reg <= frame_id_reg + 8'd1;
      if (histo_done && state_reg != IDLE) overrun_reg <= 1'b1;
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= push_word;
  end

endmodule

// File: tb/tb_histo_readout.sv
// Directed bench for histo_readout: a 16-bin instance against a bin*3 memory model and a
// 1024-bin instance against all-ones counts.
module tb_histo_readout;

  localparam int NB = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        histo_done = 1'b0;
  logic        m_ready = 1'b1;
  logic        hist_rw, m_valid, m_last, busy, overrun;
  logic [9:0]  hist_bin;
  logic [23:0] hist_data;
  logic [31:0] m_data;
  logic [7:0]  frame_id;

  logic        histo_done2 = 1'b0;
  logic        m_ready2 = 1'b1;
  logic [23:0] hist_data2 = 24'hFFFFFF;
  logic        hist_rw2, m_valid2, m_last2, busy2, overrun2;
  logic [9:0]  hist_bin2;
  logic [31:0] m_data2;
  logic [7:0]  frame_id2;

  always #5 clk = ~clk;

  histo_readout #(.NUM_BINS(NB), .RD_LATENCY(2), .FIFO_DEPTH(4), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .histo_done(histo_done), .hist_rw(hist_rw), .hist_bin(hist_bin),
    .hist_data(hist_data), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .busy(busy), .frame_id(frame_id), .overrun(overrun)
  );

  histo_readout #(.NUM_BINS(1024), .RD_LATENCY(2), .FIFO_DEPTH(4), .SYNC_BYTE(8'hA5)) dut2 (
    .clk(clk), .rst(rst), .histo_done(histo_done2), .hist_rw(hist_rw2), .hist_bin(hist_bin2),
    .hist_data(hist_data2), .m_data(m_data2), .m_valid(m_valid2), .m_ready(m_ready2),
    .m_last(m_last2), .busy(busy2), .frame_id(frame_id2), .overrun(overrun2)
  );

  // Histogram memory model: bin i holds i*3, two-cycle read latency.
  logic [23:0] mem_d1, mem_d2;
  always @(posedge clk) begin
    mem_d1 <= 24'(hist_bin) * 24'd3;
    mem_d2 <= mem_d1;
  end
  assign hist_data = mem_d2;

  logic [31:0] got_data[$];
  logic        got_last[$];
  int          total = 0;
  int          bad = 0;
  int          bin_err = 0;
  int          stable_err = 0;
  int          occ_err = 0;
  int          ready_mode = 0;
  int          cnt2 = 0;
  logic [31:0] last2 = '0;
  logic [9:0]  prev_bin = '0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;

  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      got_data.push_back(m_data);
      got_last.push_back(m_last);
      $display("  word %0d data=%h last=%b", got_data.size() - 1, m_data, m_last);
    end
    if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last))
      stable_err <= stable_err + 1;
    prev_stall <= m_valid && !m_ready && !rst;
    prev_data  <= m_data;
    prev_last  <= m_last;
    if (busy && !(hist_bin == prev_bin || hist_bin == prev_bin + 10'd1 ||
                  (prev_bin == 10'(NB - 1) && hist_bin == 10'd0)))
      bin_err <= bin_err + 1;
    prev_bin <= hist_bin;
    if (dut.count_reg > 4) occ_err <= occ_err + 1;
    if (m_valid2 && m_ready2) begin
      cnt2 <= cnt2 + 1;
      if (m_last2) last2 <= m_data2;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ($urandom_range(0, 1) == 1);
        default: m_ready = 1'b0;
      endcase
    end
  end

  function automatic logic [31:0] exp_word(input logic [7:0] fid, input int i);
    if (i == 0) return {8'hA5, fid, 16'h0010};
    if (i == NB + 1) return 32'd360;
    return 32'(3 * (i - 1));
  endfunction

  task automatic pulse_done;
    @(posedge clk);
    #1;
    histo_done = 1'b1;
    @(posedge clk);
    #1;
    histo_done = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output bit timed_out);
    int n;
    n = 0;
    while (busy && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    timed_out = busy;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (hist_rw !== 1'b1) begin bad++; $display("FAIL reset_hist_rw got=%b want=1", hist_rw); end
    total++; if (hist_bin !== 10'd0) begin bad++; $display("FAIL reset_hist_bin got=%0d want=0", hist_bin); end
    total++; if ({m_valid, m_last, busy, overrun} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b want=0000", {m_valid, m_last, busy, overrun}); end
    total++; if (m_data !== 32'd0) begin bad++; $display("FAIL reset_m_data got=%h want=0", m_data); end
    total++; if (frame_id !== 8'd0) begin bad++; $display("FAIL reset_frame_id got=%0d want=0", frame_id); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++; if (busy !== 1'b0 || hist_rw !== 1'b1) begin bad++; $display("FAIL reset_release busy=%b hist_rw=%b want 0/1", busy, hist_rw); end
  endtask

  task automatic test_basic;
    int base;
    bit to;
    ready_mode = 0;
    base = got_data.size();
    pulse_done;
    total++; if (busy !== 1'b1 || hist_rw !== 1'b0) begin bad++; $display("FAIL basic_start busy=%b hist_rw=%b want 1/0", busy, hist_rw); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL basic_early_word got m_valid=%b want 0", m_valid); end
    @(posedge clk);
    #1;
    total++; if (m_valid !== 1'b1 || m_data !== 32'hA5000010) begin bad++; $display("FAIL basic_header valid=%b data=%h want 1/a5000010", m_valid, m_data); end
    wait_idle(300, to);
    total++; if (to) begin bad++; $display("FAIL basic_timeout busy=%b want 0", busy); end
    total++; if (got_data.size() - base !== NB + 2) begin bad++; $display("FAIL basic_len got=%0d want=%0d", got_data.size() - base, NB + 2); end
    for (int i = 0; i < NB + 2; i++) begin
      if (base + i < got_data.size()) begin
        total++;
        if (got_data[base + i] !== exp_word(8'd0, i) || got_last[base + i] !== (i == NB + 1))
          begin bad++; $display("FAIL basic_word%0d got=%h/%b want=%h/%b", i, got_data[base + i], got_last[base + i], exp_word(8'd0, i), (i == NB + 1)); end
      end
    end
    total++; if (frame_id !== 8'd1 || hist_rw !== 1'b1) begin bad++; $display("FAIL basic_end frame_id=%0d hist_rw=%b want 1/1", frame_id, hist_rw); end
    total++; if (hist_bin !== 10'(NB - 1)) begin bad++; $display("FAIL basic_last_bin got=%0d want=%0d", hist_bin, NB - 1); end
  endtask

  task automatic test_random_ready;
    int base, b0, s0, o0;
    bit to;
    base = got_data.size();
    b0 = bin_err; s0 = stable_err; o0 = occ_err;
    ready_mode = 1;
    pulse_done;
    wait_idle(600, to);
    ready_mode = 0;
    total++; if (to) begin bad++; $display("FAIL random_timeout busy=%b want 0", busy); end
    total++; if (got_data.size() - base !== NB + 2) begin bad++; $display("FAIL random_len got=%0d want=%0d", got_data.size() - base, NB + 2); end
    for (int i = 0; i < NB + 2; i++) begin
      if (base + i < got_data.size()) begin
        total++;
        if (got_data[base + i] !== exp_word(8'd1, i) || got_last[base + i] !== (i == NB + 1))
          begin bad++; $display("FAIL random_word%0d got=%h/%b want=%h/%b", i, got_data[base + i], got_last[base + i], exp_word(8'd1, i), (i == NB + 1)); end
      end
    end
    total++; if (bin_err - b0 !== 0) begin bad++; $display("FAIL random_bin_order errors=%0d want 0", bin_err - b0); end
    total++; if (stable_err - s0 !== 0) begin bad++; $display("FAIL random_stable errors=%0d want 0", stable_err - s0); end
    total++; if (occ_err - o0 !== 0) begin bad++; $display("FAIL random_occupancy errors=%0d want 0", occ_err - o0); end
    total++; if (frame_id !== 8'd2) begin bad++; $display("FAIL random_frame_id got=%0d want=2", frame_id); end
  endtask

  task automatic test_stall;
    int base, s0;
    bit to;
    base = got_data.size();
    s0 = stable_err;
    ready_mode = 2;
    pulse_done;
    repeat (100) @(posedge clk);
    #1;
    total++; if (hist_bin !== 10'd2) begin bad++; $display("FAIL stall_hist_bin got=%0d want=2", hist_bin); end
    total++; if (m_valid !== 1'b1 || m_data !== exp_word(8'd2, 0) || m_last !== 1'b0) begin bad++; $display("FAIL stall_head valid=%b data=%h last=%b want 1/%h/0", m_valid, m_data, m_last, exp_word(8'd2, 0)); end
    total++; if (got_data.size() !== base) begin bad++; $display("FAIL stall_no_transfer got=%0d want=%0d", got_data.size(), base); end
    ready_mode = 0;
    wait_idle(300, to);
    total++; if (to) begin bad++; $display("FAIL stall_timeout busy=%b want 0", busy); end
    total++; if (got_data.size() - base !== NB + 2) begin bad++; $display("FAIL stall_len got=%0d want=%0d", got_data.size() - base, NB + 2); end
    for (int i = 0; i < NB + 2; i++) begin
      if (base + i < got_data.size()) begin
        total++;
        if (got_data[base + i] !== exp_word(8'd2, i) || got_last[base + i] !== (i == NB + 1))
          begin bad++; $display("FAIL stall_word%0d got=%h/%b want=%h/%b", i, got_data[base + i], got_last[base + i], exp_word(8'd2, i), (i == NB + 1)); end
      end
    end
    total++; if (stable_err - s0 !== 0) begin bad++; $display("FAIL stall_stable errors=%0d want 0", stable_err - s0); end
    total++; if (frame_id !== 8'd3) begin bad++; $display("FAIL stall_frame_id got=%0d want=3", frame_id); end
  endtask

  task automatic test_trailer_coincide;
    int base, n;
    base = got_data.size();
    ready_mode = 0;
    pulse_done;
    n = 0;
    while (!(m_valid && m_last) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++; if (!(m_valid && m_last)) begin bad++; $display("FAIL coincide_find_trailer valid=%b last=%b want 1/1", m_valid, m_last); end
    histo_done = 1'b1;
    @(posedge clk);
    #1;
    histo_done = 1'b0;
    total++; if (busy !== 1'b0 || overrun !== 1'b1) begin bad++; $display("FAIL coincide_state busy=%b overrun=%b want 0/1", busy, overrun); end
    total++; if (frame_id !== 8'd4) begin bad++; $display("FAIL coincide_frame_id got=%0d want=4", frame_id); end
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0 || m_valid !== 1'b0) begin bad++; $display("FAIL coincide_ignored busy=%b valid=%b want 0/0", busy, m_valid); end
    total++; if (got_data.size() - base !== NB + 2) begin bad++; $display("FAIL coincide_len got=%0d want=%0d", got_data.size() - base, NB + 2); end
    else begin
      total++; if (got_data[base + NB + 1] !== 32'd360) begin bad++; $display("FAIL coincide_trailer got=%h want=%h", got_data[base + NB + 1], 32'd360); end
    end
  endtask

  task automatic test_mid_reset;
    int base, n;
    bit to;
    ready_mode = 0;
    pulse_done;
    n = 0;
    while (hist_bin !== 10'd7 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++; if (hist_bin !== 10'd7) begin bad++; $display("FAIL midrst_reach_bin got=%0d want=7", hist_bin); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (hist_rw !== 1'b1 || hist_bin !== 10'd0) begin bad++; $display("FAIL midrst_hist rw=%b bin=%0d want 1/0", hist_rw, hist_bin); end
    total++; if ({m_valid, m_last, busy, overrun} !== 4'b0000 || m_data !== 32'd0) begin bad++; $display("FAIL midrst_out flags=%b data=%h want 0000/0", {m_valid, m_last, busy, overrun}, m_data); end
    total++; if (frame_id !== 8'd0) begin bad++; $display("FAIL midrst_frame_id got=%0d want=0", frame_id); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    base = got_data.size();
    pulse_done;
    wait_idle(300, to);
    total++; if (to) begin bad++; $display("FAIL midrst_timeout busy=%b want 0", busy); end
    total++; if (got_data.size() - base !== NB + 2) begin bad++; $display("FAIL midrst_len got=%0d want=%0d", got_data.size() - base, NB + 2); end
    for (int i = 0; i < NB + 2; i++) begin
      if (base + i < got_data.size()) begin
        total++;
        if (got_data[base + i] !== exp_word(8'd0, i) || got_last[base + i] !== (i == NB + 1))
          begin bad++; $display("FAIL midrst_word%0d got=%h/%b want=%h/%b", i, got_data[base + i], got_last[base + i], exp_word(8'd0, i), (i == NB + 1)); end
      end
    end
    total++; if (frame_id !== 8'd1) begin bad++; $display("FAIL midrst_frame_id_end got=%0d want=1", frame_id); end
  endtask

  task automatic test_overrun;
    int base;
    bit to;
    ready_mode = 0;
    base = got_data.size();
    pulse_done;
    repeat (5) @(posedge clk);
    #1;
    pulse_done;
    total++; if (overrun !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL overrun_set overrun=%b busy=%b want 1/1", overrun, busy); end
    wait_idle(300, to);
    total++; if (to) begin bad++; $display("FAIL overrun_timeout busy=%b want 0", busy); end
    total++; if (got_data.size() - base !== NB + 2) begin bad++; $display("FAIL overrun_len got=%0d want=%0d", got_data.size() - base, NB + 2); end
    for (int i = 0; i < NB + 2; i++) begin
      if (base + i < got_data.size()) begin
        total++;
        if (got_data[base + i] !== exp_word(8'd1, i) || got_last[base + i] !== (i == NB + 1))
          begin bad++; $display("FAIL overrun_word%0d got=%h/%b want=%h/%b", i, got_data[base + i], got_last[base + i], exp_word(8'd1, i), (i == NB + 1)); end
      end
    end
    base = got_data.size();
    pulse_done;
    wait_idle(300, to);
    total++; if (to) begin bad++; $display("FAIL overrun_next_timeout busy=%b want 0", busy); end
    total++; if (got_data.size() - base !== NB + 2) begin bad++; $display("FAIL overrun_next_len got=%0d want=%0d", got_data.size() - base, NB + 2); end
    else begin
      total++; if (got_data[base] !== exp_word(8'd2, 0)) begin bad++; $display("FAIL overrun_next_header got=%h want=%h", got_data[base], exp_word(8'd2, 0)); end
      total++; if (got_data[base + NB + 1] !== 32'd360 || got_last[base + NB + 1] !== 1'b1) begin bad++; $display("FAIL overrun_next_trailer got=%h/%b want=%h/1", got_data[base + NB + 1], got_last[base + NB + 1], 32'd360); end
    end
    total++; if (overrun !== 1'b1 || frame_id !== 8'd3) begin bad++; $display("FAIL overrun_sticky overrun=%b frame_id=%0d want 1/3", overrun, frame_id); end
  endtask

  task automatic test_full_range;
    int base, n;
    base = cnt2;
    @(posedge clk);
    #1;
    histo_done2 = 1'b1;
    @(posedge clk);
    #1;
    histo_done2 = 1'b0;
    n = 0;
    while (busy2 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL full_timeout busy=%b want 0", busy2); end
    total++; if (cnt2 - base !== 1026) begin bad++; $display("FAIL full_len got=%0d want=1026", cnt2 - base); end
    total++; if (last2 !== 32'hFFFFFC00) begin bad++; $display("FAIL full_trailer got=%h want=fffffc00", last2); end
    total++; if (frame_id2 !== 8'd1 || hist_bin2 !== 10'd1023 || hist_rw2 !== 1'b1 || overrun2 !== 1'b0)
      begin bad++; $display("FAIL full_end frame_id=%0d bin=%0d rw=%b overrun=%b want 1/1023/1/0", frame_id2, hist_bin2, hist_rw2, overrun2); end
    $display("  full frame words=%0d trailer=%h", cnt2 - base, last2);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_random_ready;
    test_stall;
    test_trailer_coincide;
    test_mid_reset;
    test_overrun;
    test_full_range;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
